// File: rtl/reg_alu_pipe.sv
// Two-stage register-file ALU: operand read and compute, then writeback.
// Stage-1 result forwards to both read ports until it lands in the file.
module reg_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sel,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out_a,
  output logic [WIDTH-1:0] d_out_b,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [WIDTH-1:0] r_result;
  logic [AW-1:0]    r_wb_addr;
  logic             r_valid;
  logic             r_cout;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_alu;
  logic             w_c;
  logic             w_v;
  logic             w_fwd_a;
  logic             w_fwd_b;

  // Pending stage-1 value shadows the file until its writeback edge
  assign w_fwd_a = r_valid && (r_wb_addr == rd_addr_a);
  assign w_fwd_b = r_valid && (r_wb_addr == rd_addr_b);
  assign w_a = w_fwd_a ? r_result : r_regs[rd_addr_a];
  assign w_b = w_fwd_b ? r_result : r_regs[rd_addr_b];

  assign d_out_a = w_a;
  assign d_out_b = w_b;

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_dif = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_alu = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (op_e'(op))
      OP_ADD: begin
        w_alu = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu = w_dif[WIDTH-1:0];
        w_c   = ~w_dif[WIDTH];
        w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                (w_dif[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND: w_alu = w_a & w_b;
      OP_OR:  w_alu = w_a | w_b;
      OP_XOR: w_alu = w_a ^ w_b;
      OP_NOT: w_alu = ~w_a;
      OP_SHL: begin
        w_alu = {w_a[WIDTH-2:0], 1'b0};
        w_c   = w_a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu = {1'b0, w_a[WIDTH-1:1]};
        w_c   = w_a[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_result  <= '0;
      r_wb_addr <= '0;
      r_valid   <= 1'b0;
      r_cout    <= 1'b0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (r_valid) r_regs[r_wb_addr] <= r_result;
      r_valid <= en;
      if (en) begin
        r_result  <= sel ? w_alu : d_in;
        r_wb_addr <= wr_addr;
        if (sel) begin
          r_cout <= w_c;
          r_zero <= (w_alu == '0);
          r_neg  <= w_alu[WIDTH-1];
          r_ovf  <= w_v;
        end
      end
    end
  end

  assign result    = r_result;
  assign res_valid = r_valid;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Scoreboard bench for reg_alu_pipe at 16x8 and 8x4.
// Sequential-semantics model; expected results queued at issue.
module tb_reg_alu_pipe;

  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, sel;
  logic [2:0]    op;
  logic [2:0]    ra, rb, wa;
  logic [W-1:0]  din;
  logic [W-1:0]  d_out_a, d_out_b, result;
  logic          res_valid, cout, zero, neg, ovf;

  logic          reset8, en8, sel8;
  logic [2:0]    op8;
  logic [1:0]    ra8, rb8, wa8;
  logic [7:0]    din8;
  logic [7:0]    da8, db8, result8;
  logic          valid8, cout8, zero8, neg8, ovf8;

  reg_alu_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .en(en), .sel(sel), .op(op),
    .rd_addr_a(ra), .rd_addr_b(rb), .wr_addr(wa), .d_in(din),
    .d_out_a(d_out_a), .d_out_b(d_out_b), .result(result),
    .res_valid(res_valid), .cout(cout), .zero(zero),
    .neg(neg), .ovf(ovf)
  );

  reg_alu_pipe #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .reset(reset8), .en(en8), .sel(sel8), .op(op8),
    .rd_addr_a(ra8), .rd_addr_b(rb8), .wr_addr(wa8), .d_in(din8),
    .d_out_a(da8), .d_out_b(db8), .result(result8),
    .res_valid(valid8), .cout(cout8), .zero(zero8),
    .neg(neg8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [W-1:0] v;
    logic [3:0]   f;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m[D];
  logic [3:0]   mf;
  int           n_chk = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns {value, cout, zero, neg, ovf} using integer arithmetic
  function automatic logic [W+3:0] alu_m(input logic [2:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int ua, ub, sa, sb, r;
    logic [W-1:0] v;
    logic c, ov;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    v = '0; c = 1'b0; ov = 1'b0;
    case (o)
      3'd0: begin
        r = ua + ub; v = r[W-1:0]; c = (r > 65535);
        r = sa + sb; ov = (r > 32767) || (r < -32768);
      end
      3'd1: begin
        r = ua - ub; v = r[W-1:0]; c = (a >= b);
        r = sa - sb; ov = (r > 32767) || (r < -32768);
      end
      3'd2: v = a & b;
      3'd3: v = a | b;
      3'd4: v = a ^ b;
      3'd5: v = ~a;
      3'd6: begin r = ua * 2; v = r[W-1:0]; c = (a >= 16'h8000); end
      default: begin v = W'(ua / 2); c = (ua % 2) == 1; end
    endcase
    return {v, c, (v == 0), (a == a) && ($signed(v) < 0), ov};
  endfunction

  task automatic issue(input logic s, input logic [2:0] o, input int a,
                       input int b, input int w, input logic [W-1:0] d);
    exp_t e;
    logic [W+3:0] f;
    en = 1'b1; sel = s; op = o;
    ra = 3'(a); rb = 3'(b); wa = 3'(w); din = d;
    f = alu_m(o, m[a], m[b]);
    if (s) begin
      e.v = f[W+3:4];
      mf = f[3:0];
    end else begin
      e.v = d;
    end
    e.f = mf;
    q.push_back(e);
    m[w] = e.v;
    @(posedge clk); #1;
    en = 1'b0;
    chk("valid", res_valid, 1);
    if (q.size() == 0) begin
      chk("queue_empty", 0, 1);
    end else begin
      e = q.pop_front();
      chk("result", result, e.v);
      chk("flags", {cout, zero, neg, ovf}, e.f);
    end
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", res_valid, 0);
  endtask

  task automatic rd(input int a, input int b);
    ra = 3'(a); rb = 3'(b);
    #1;
    chk("rd_a", d_out_a, m[a]);
    chk("rd_b", d_out_b, m[b]);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; sel = 1'b0; op = '0;
    ra = '0; rb = '0; wa = '0; din = '0;
    reset8 = 1'b0; en8 = 1'b0; sel8 = 1'b0; op8 = '0;
    ra8 = '0; rb8 = '0; wa8 = '0; din8 = '0;
    for (int i = 0; i < D; i++) m[i] = '0;
    mf = '0;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) rd(i, (i + 1) % D);
    chk("rst_valid", res_valid, 0);
    chk("rst_flags", {cout, zero, neg, ovf}, 4'b0000);

    // Issue in the first cycle out of reset
    reset = 1'b1;
    issue(0, 3'd0, 0, 0, 1, 16'h7FFF);
    issue(0, 3'd0, 0, 0, 2, 16'h0001);
    issue(1, 3'd0, 1, 2, 3, 16'h0000);
    chk("add_res", result, 16'h8000);
    chk("add_flags", {cout, zero, neg, ovf}, 4'b0011);
    idle();
    rd(3, 3);
    chk("add_r3", d_out_a, 16'h8000);

    issue(0, 3'd0, 0, 0, 4, 16'h00F0);
    issue(1, 3'd2, 4, 4, 5, 16'h0000);
    chk("fwd_res", result, 16'h00F0);
    idle();
    idle();
    rd(5, 4);
    chk("fwd_r5", d_out_a, 16'h00F0);

    issue(0, 3'd0, 0, 0, 1, 16'd5);
    issue(0, 3'd0, 0, 0, 2, 16'd5);
    issue(1, 3'd1, 1, 2, 7, 16'h0000);
    chk("sub_eq", result, 16'h0000);
    chk("sub_eq_zc", {zero, cout}, 2'b11);
    issue(0, 3'd0, 0, 0, 1, 16'd3);
    issue(1, 3'd1, 1, 2, 7, 16'h0000);
    chk("sub_lt", result, 16'hFFFE);
    chk("sub_lt_cn", {cout, neg}, 2'b01);

    issue(0, 3'd0, 0, 0, 0, 16'h8001);
    issue(1, 3'd6, 0, 0, 1, 16'h0000);
    chk("shl_res", result, 16'h0002);
    chk("shl_c", cout, 1);
    issue(0, 3'd0, 0, 0, 2, 16'h0055);
    chk("hold_c", cout, 1);
    issue(1, 3'd0, 2, 2, 2, 16'h0000);
    chk("same_addr", result, 16'h00AA);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 5) == 0) idle();
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom_range(0, D - 1), $urandom_range(0, D - 1),
            $urandom_range(0, D - 1), 16'($urandom));
    end
    idle();
    idle();
    for (int i = 0; i < D; i++) rd(i, D - 1 - i);

    // Reset lands on the writeback cycle of r6
    issue(0, 3'd0, 0, 0, 6, 16'h1234);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < D; i++) m[i] = '0;
    mf = '0;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {cout, zero, neg, ovf}, 4'b0000);
    rd(6, 6);
    issue(0, 3'd0, 0, 0, 6, 16'hBEEF);
    idle();
    rd(6, 0);

    // Narrow instance: 0xFF + 0x01 wraps to zero with carry
    @(posedge clk); #1;
    reset8 = 1'b1;
    en8 = 1'b1; sel8 = 1'b0; wa8 = 2'd0; din8 = 8'hFF;
    @(posedge clk); #1;
    wa8 = 2'd1; din8 = 8'h01;
    @(posedge clk); #1;
    sel8 = 1'b1; op8 = 3'd0; ra8 = 2'd0; rb8 = 2'd1; wa8 = 2'd2;
    @(posedge clk); #1;
    en8 = 1'b0;
    chk("w8_valid", valid8, 1);
    chk("w8_result", result8, 8'h00);
    chk("w8_flags", {cout8, zero8, neg8, ovf8}, 4'b1100);
    @(posedge clk); #1;
    ra8 = 2'd2; rb8 = 2'd0;
    #1;
    chk("w8_r2", da8, 8'h00);
    chk("w8_r0", db8, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
